// File: rtl/sqrt_r2.sv
// Iterative restoring integer square root: one root bit per clock, start/done handshake.
// Optional `exact` output (rem == 0) is built only when SQRT_EXACT_EN is defined.
module sqrt_r2 #(
   parameter int OUT_W = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [2*OUT_W-1:0] opa,
   output logic               busy,
   output logic               done,
   output logic [OUT_W-1:0]   root,
   output logic [OUT_W:0]     rem
`ifdef SQRT_EXACT_EN
   ,output logic              exact
`endif
);

   localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

   typedef enum logic {IDLE, CALC} state_t;

   state_t             state_q, state_d;
   logic [2*OUT_W-1:0] op_q, op_d;
   logic [OUT_W-1:0]   q_q, q_d;
   logic [OUT_W:0]     r_q, r_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [OUT_W-1:0]   root_q, root_d;
   logic [OUT_W:0]     rem_q, rem_d;

   // Partial remainder never exceeds 2*q, so OUT_W+1 bits hold it; the trial sign
   // comes from an unsigned compare, and the subtract only needs the low bits.
   logic [OUT_W+2:0]   r_shift, sub;
   logic [OUT_W:0]     trial;
   logic               take;
   logic [OUT_W-1:0]   q_next;
   logic [OUT_W:0]     r_next;

   assign r_shift = {r_q, op_q[2*OUT_W-1 -: 2]};
   assign sub     = {1'b0, q_q, 2'b01};
   assign take    = (r_shift >= sub);
   assign trial   = r_shift[OUT_W:0] - sub[OUT_W:0];
   assign q_next  = {q_q[OUT_W-2:0], take};
   assign r_next  = take ? trial : r_shift[OUT_W:0];

`ifdef SQRT_EXACT_EN
   logic exact_q, exact_d;
`endif

   always_comb begin
      // NOTE: every target gets a default first, so no path through the case leaves a latch.
      state_d = state_q;
      op_d    = op_q;
      q_d     = q_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      root_d  = root_q;
      rem_d   = rem_q;
`ifdef SQRT_EXACT_EN
      exact_d = exact_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d    = opa;
               q_d     = '0;
               r_d     = '0;
               cnt_d   = CW'(OUT_W - 1);
               busy_d  = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            op_d  = {op_q[2*OUT_W-3:0], 2'b00};
            q_d   = q_next;
            r_d   = r_next;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               root_d  = q_next;
               rem_d   = r_next;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
`ifdef SQRT_EXACT_EN
               exact_d = (r_next == '0);
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         q_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         root_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         q_q     <= q_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         root_q  <= root_d;
         rem_q   <= rem_d;
      end
   end

`ifdef SQRT_EXACT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) exact_q <= 1'b0;
      else     exact_q <= exact_d;
   end
   assign exact = exact_q;
`endif

   assign busy = busy_q;
   assign done = done_q;
   assign root = root_q;
   assign rem  = rem_q;

endmodule

// File: tb/tb_sqrt_r2.sv
// Self-checking bench for sqrt_r2: vector table, handshake corner cases, and
// random operands against a binary-search square-root reference.
module tb_sqrt_r2;

   logic        clk;
   logic        rst;
   logic        start;
   logic [47:0] opa;
   logic        busy;
   logic        done;
   logic [23:0] root;
   logic [24:0] rem;
`ifdef SQRT_EXACT_EN
   logic        exact;
`endif

   int checks   = 0;
   int failures = 0;

   sqrt_r2 #(.OUT_W(24)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .opa   (opa),
      .busy  (busy),
      .done  (done),
      .root  (root),
      .rem   (rem)
`ifdef SQRT_EXACT_EN
      ,.exact(exact)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [47:0] a;
      logic [23:0] r;
      logic [24:0] m;
      bit          ex;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: largest r with r*r <= x, found by binary search on plain integers.
   function automatic logic [23:0] ref_root(input logic [47:0] x);
      longint unsigned lo, hi, mid, xv;
      xv = 64'(x);
      lo = 0;
      hi = 64'hFF_FFFF;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= xv) lo = mid;
         else                 hi = mid - 1;
      end
      return lo[23:0];
   endfunction

   function automatic logic [24:0] ref_rem(input logic [47:0] x);
      longint unsigned r;
      r = 64'(ref_root(x));
      return 25'(64'(x) - r * r);
   endfunction

   task automatic check_result(input string name, input logic [23:0] er, input logic [24:0] em);
      check({name, ".root"}, 64'(root), 64'(er));
      check({name, ".rem"},  64'(rem),  64'(em));
`ifdef SQRT_EXACT_EN
      check({name, ".exact"}, 64'(exact), 64'(em == 25'd0));
`endif
   endtask

   // One full operation: accept, count busy cycles and latency, then check result.
   task automatic do_op(input logic [47:0] a, input logic [23:0] er, input logic [24:0] em,
                        input string name);
      int lat;
      int busy_cnt;
      bit seen;
      opa   = a;
      start = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      busy_cnt = busy ? 1 : 0;
      lat      = 0;
      seen     = 1'b0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(posedge clk); #1;
         lat = i;
         if (done) seen = 1'b1;
         else if (busy) busy_cnt++;
      end
      check({name, ".done_seen"}, 64'(seen), 64'd1);
      check({name, ".latency"}, 64'(lat), 64'd24);
      check({name, ".busy_cycles"}, 64'(busy_cnt), 64'd24);
      check({name, ".busy_at_done"}, 64'(busy), 64'd0);
      check_result(name, er, em);
      @(posedge clk); #1;
      check({name, ".done_one_cycle"}, 64'(done), 64'd0);
   endtask

   vec_t vecs[7];

   initial begin
      int first_done;
      int second_done;
      int done_cnt;
      logic [47:0] a;
      logic [23:0] rr;

      vecs[0] = '{48'd144,            24'd12,       25'd0,         1'b1};
      vecs[1] = '{48'hFFFF_FFFF_FFFF, 24'hFF_FFFF,  25'h1FF_FFFE,  1'b0};
      vecs[2] = '{48'd2,              24'd1,        25'd1,         1'b0};
      vecs[3] = '{48'h4000_0000_0000, 24'h80_0000,  25'd0,         1'b1};
      vecs[4] = '{48'd0,              24'd0,        25'd0,         1'b1};
      vecs[5] = '{48'd49,             24'd7,        25'd0,         1'b1};
      vecs[6] = '{48'd50,             24'd7,        25'd1,         1'b0};

      rst   = 1'b1;
      start = 1'b0;
      opa   = '0;
      #12;
      check("reset.busy", 64'(busy), 64'd0);
      check("reset.done", 64'(done), 64'd0);
      check("reset.root", 64'(root), 64'd0);
      check("reset.rem",  64'(rem),  64'd0);
`ifdef SQRT_EXACT_EN
      check("reset.exact", 64'(exact), 64'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++)
         do_op(vecs[i].a, vecs[i].r, vecs[i].m, $sformatf("vec%0d", i));

      // start while busy is ignored; opa left changed to prove no resample
      opa   = 48'd144;
      start = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
      done_cnt   = 0;
      first_done = -1;
      for (int i = 1; i <= 54; i++) begin
         if (i == 5) begin
            start = 1'b1;
            opa   = 48'd10000;
         end
         if (i == 6) start = 1'b0;
         @(posedge clk); #1;
         if (done) begin
            done_cnt++;
            if (first_done < 0) begin
               first_done = i;
               check_result("ignore_start", 24'd12, 25'd0);
            end
         end
      end
      check("ignore_start.latency", 64'(first_done), 64'd24);
      check("ignore_start.done_count", 64'(done_cnt), 64'd1);

      // start held high: back-to-back operations, opa changed on the done cycle
      opa   = 48'd49;
      start = 1'b1;
      @(posedge clk); #1;
      first_done  = -1;
      second_done = -1;
      for (int i = 1; i <= 70 && second_done < 0; i++) begin
         @(posedge clk); #1;
         if (done) begin
            if (first_done < 0) begin
               first_done = i;
               check_result("b2b_first", 24'd7, 25'd0);
               check("b2b.busy_dropped", 64'(busy), 64'd0);
               opa = 48'd50;
            end else begin
               second_done = i;
               check_result("b2b_second", 24'd7, 25'd1);
               start = 1'b0;
            end
         end else if (first_done > 0 && i == first_done + 1) begin
            check("b2b.no_bubble_busy", 64'(busy), 64'd1);
            check("b2b.held_root", 64'(root), 64'd7);
         end
      end
      start = 1'b0;
      check("b2b.first_latency", 64'(first_done), 64'd24);
      check("b2b.period", 64'(second_done - first_done), 64'd25);

      // reset mid-operation aborts with no done
      @(posedge clk); #1;
      opa   = 48'd144;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i < 10; i++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      check("abort.busy", 64'(busy), 64'd0);
      check("abort.done", 64'(done), 64'd0);
      check("abort.root", 64'(root), 64'd0);
      check("abort.rem",  64'(rem),  64'd0);
      @(posedge clk); #1;
      rst      = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) done_cnt++;
      end
      check("abort.no_done", 64'(done_cnt), 64'd0);
      do_op(48'd144, 24'd12, 25'd0, "after_abort");

      // random operands and near-squares against the reference
      for (int i = 0; i < 24; i++) begin
         if (i % 3 == 0) begin
            a = {16'($urandom), 32'($urandom)};
         end else begin
            rr = 24'($urandom);
            a  = 48'(64'(rr) * 64'(rr));
            if (i % 3 == 2 && a != 48'd0) a = a - 48'd1;
         end
         do_op(a, ref_root(a), ref_rem(a), $sformatf("rand%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
